// File: rtl/c3lib_cdc_hs_tx.sv
// Source side of a 4-phase req/ack CDC handshake. It holds a word on a quasi-static
// bus, raises req_out, and completes the transfer once the synchronized ack has risen and fallen.
module c3lib_cdc_hs_tx #(
  parameter int               WIDTH        = 8,
  parameter int               SYNC_STAGES  = 2,
  parameter logic [WIDTH-1:0] DATA_RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_rdy,
  output logic             req_out,
  output logic [WIDTH-1:0] data_out,
  input  logic             ack_in,
  output logic             done,
  output logic             err_ack
);

  typedef enum logic [1:0] {IDLE, REQ, REL} state_e;

  state_e             state_q, state_d;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic               ack_s, ack_s_nxt;
  logic               rdy_q, rdy_d;
  logic               req_q, req_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_sync_q <= '0;
    else        ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_in};
  end

  assign ack_s     = ack_sync_q[SYNC_STAGES-1];
  // The value ack_s takes on this edge. err_ack therefore rises together with ack_s, not one cycle later.
  assign ack_s_nxt = ack_sync_q[SYNC_STAGES-2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b1;
      req_q   <= 1'b0;
      data_q  <= DATA_RST_VAL;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rdy_d   = rdy_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = err_q | ((state_q == IDLE) & ack_s_nxt);
    case (state_q)
      IDLE: if (in_vld) begin
        data_d  = in_data;
        req_d   = 1'b1;
        rdy_d   = 1'b0;
        state_d = REQ;
      end
      REQ: if (ack_s) begin
        req_d   = 1'b0;
        state_d = REL;
      end
      REL: if (!ack_s) begin
        rdy_d   = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        rdy_d   = 1'b1;
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign in_rdy   = rdy_q;
  assign req_out  = req_q;
  assign data_out = data_q;
  assign done     = done_q;
  assign err_ack  = err_q;

endmodule

// File: tb/tb_c3lib_cdc_hs_tx.sv
// Directed bench for c3lib_cdc_hs_tx. DUT a uses 2 sync stages and a 3-cycle echo responder.
// DUT b uses 4 sync stages and is driven as a slow manual responder.
module tb_c3lib_cdc_hs_tx;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_vld_a, in_vld_b;
  logic [7:0] in_data_a, in_data_b;
  logic       in_rdy_a, in_rdy_b, req_a, req_b, done_a, done_b, err_a, err_b;
  logic [7:0] data_a, data_b;
  logic       ack_a, ack_b;
  logic       man_en, man_ack;
  logic [2:0] rsp_sh = '0;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  always #5 clk = ~clk;

  c3lib_cdc_hs_tx #(.WIDTH(8), .SYNC_STAGES(2), .DATA_RST_VAL(8'h00)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld_a), .in_data(in_data_a), .in_rdy(in_rdy_a),
    .req_out(req_a), .data_out(data_a), .ack_in(ack_a), .done(done_a), .err_ack(err_a));

  c3lib_cdc_hs_tx #(.WIDTH(8), .SYNC_STAGES(4), .DATA_RST_VAL(8'h00)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld_b), .in_data(in_data_b), .in_rdy(in_rdy_b),
    .req_out(req_b), .data_out(data_b), .ack_in(ack_b), .done(done_b), .err_ack(err_b));

  // Echo responder: ack follows req_out three clocks later unless manually overridden.
  always @(posedge clk) rsp_sh <= {rsp_sh[1:0], req_a};
  assign ack_a = man_en ? man_ack : rsp_sh[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done_a();
    int n = 0;
    while (!done_a && n < 40) begin
      tick();
      n++;
    end
    chk("done_a_wait", {31'd0, done_a}, 32'd1);
    tick();
  endtask

  // The monitor pops the expected word whenever a transfer completes.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done_a === 1'b1) begin
      if (q_a.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL done_a_unexpected: got done with data %0h expected no completion", data_a);
      end else chk("xfer_a", {24'd0, data_a}, {24'd0, q_a.pop_front()});
    end
    if (rst_n === 1'b1 && done_b === 1'b1) begin
      if (q_b.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL done_b_unexpected: got done with data %0h expected no completion", data_b);
      end else chk("xfer_b", {24'd0, data_b}, {24'd0, q_b.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int dcnt;
    rst_n = 1'b0; in_vld_a = 0; in_vld_b = 0; in_data_a = 0; in_data_b = 0;
    ack_b = 0; man_en = 0; man_ack = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_rdy", {31'd0, in_rdy_a}, 1);
    chk("rst_req", {31'd0, req_a}, 0);
    chk("rst_data", {24'd0, data_a}, 0);
    chk("rst_done", {31'd0, done_a}, 0);
    chk("rst_err", {31'd0, err_a}, 0);

    // Single transfer. Edge 0 is the accept edge.
    in_vld_a = 1; in_data_a = 8'h3C; q_a.push_back(8'h3C);
    tick();
    in_vld_a = 0; in_data_a = 8'hE7;
    chk("single_req_e0", {31'd0, req_a}, 1);
    chk("single_data_e0", {24'd0, data_a}, 8'h3C);
    chk("single_rdy_e0", {31'd0, in_rdy_a}, 0);
    for (int e = 1; e <= 13; e++) begin
      tick();
      if (e == 5)  chk("single_req_e5", {31'd0, req_a}, 1);
      if (e == 6)  chk("single_req_e6", {31'd0, req_a}, 0);
      if (e == 11) chk("single_done_e11", {31'd0, done_a}, 0);
      if (e == 12) begin
        chk("single_done_e12", {31'd0, done_a}, 1);
        chk("single_rdy_e12", {31'd0, in_rdy_a}, 1);
      end
      if (e == 13) chk("single_done_e13", {31'd0, done_a}, 0);
    end

    // Back-to-back transfers with in_vld held high.
    in_vld_a = 1; in_data_a = 8'h11; q_a.push_back(8'h11);
    tick();
    in_data_a = 8'h22;
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk("b2b_hold", {24'd0, data_a}, 8'h11);
    end
    q_a.push_back(8'h22);
    tick();
    chk("b2b_data_e13", {24'd0, data_a}, 8'h22);
    chk("b2b_req_e13", {31'd0, req_a}, 1);
    in_vld_a = 0;
    wait_done_a();

    // Blocked input while REQ or REL is active.
    in_vld_a = 1; in_data_a = 8'h5A; q_a.push_back(8'h5A);
    tick();
    for (int e = 1; e <= 11; e++) begin
      in_data_a = e[0] ? 8'hFF : 8'h00;
      tick();
      chk("blk_data", {24'd0, data_a}, 8'h5A);
      chk("blk_rdy", {31'd0, in_rdy_a}, 0);
    end
    in_vld_a = 0;
    wait_done_a();

    // Spurious ack while IDLE.
    man_en = 1; man_ack = 1;
    tick();
    chk("spur_err_e1", {31'd0, err_a}, 0);
    tick();
    chk("spur_err_e2", {31'd0, err_a}, 1);
    man_ack = 0;
    repeat (4) tick();
    chk("spur_err_sticky", {31'd0, err_a}, 1);
    man_en = 0;

    // Slow responder on the 4-stage instance.
    in_vld_b = 1; in_data_b = 8'h77; q_b.push_back(8'h77);
    tick();
    in_vld_b = 0;
    chk("slow_req_e0", {31'd0, req_b}, 1);
    for (int e = 1; e <= 24; e++) begin
      tick();
      if (e == 20) ack_b = 1;
    end
    chk("slow_req_e24", {31'd0, req_b}, 1);
    chk("slow_data_e24", {24'd0, data_b}, 8'h77);
    tick();
    chk("slow_req_e25", {31'd0, req_b}, 0);
    ack_b = 0;
    dcnt = 0;
    for (int e = 0; e < 15; e++) begin
      tick();
      if (done_b) dcnt++;
    end
    chk("slow_done_count", dcnt, 1);
    chk("slow_err_b", {31'd0, err_b}, 0);

    // Asynchronous reset in the middle of REQ.
    in_vld_a = 1; in_data_a = 8'hA5;
    tick();
    in_vld_a = 0;
    chk("mid_data", {24'd0, data_a}, 8'hA5);
    chk("mid_req", {31'd0, req_a}, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, req_a}, 0);
    chk("arst_data", {24'd0, data_a}, 0);
    chk("arst_rdy", {31'd0, in_rdy_a}, 1);
    chk("arst_err", {31'd0, err_a}, 0);
    repeat (4) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_err", {31'd0, err_a}, 0);

    chk("q_a_empty", q_a.size(), 0);
    chk("q_b_empty", q_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
